div_seq_nbits: RTL
==================

# div_seq_nbits

Sequential unsigned restoring divider for the calculator datapath: `width` iterations of shift-and-subtract produce a quotient and remainder from a dividend and divisor. It is the multi-cycle counterpart to the combinational adder/subtractor and reuses that adder/subtractor as its trial-subtract stage. It sits beside the ALU and is launched by the calculator control FSM with a start/done handshake.

## Interface
- `width`, 8: operand, quotient and remainder width in bits (≥ 2).

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous and active-low.
- `start_i`  in  1  request a division; sampled only in IDLE.
- `dividend_i`  in  width  unsigned dividend; captured on an accepted start.
- `divisor_i`  in  width  unsigned divisor; captured on an accepted start.
- `busy_o`  out  1  high from the edge accepting start until the edge entering IDLE.
- `done_o`  out  1  one-cycle pulse; results valid.
- `quotient_o`  out  width  quotient; held until the next accepted start.
- `remainder_o`  out  width  remainder; held until the next accepted start.
- `div_by_zero_o`  out  1  high with and after `done_o` when the captured divisor was 0; cleared on the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start_i`=1, captured divisor ≠ 0:
  - load the quotient shift register with the dividend;
  - clear the remainder, clear the counter, clear `div_by_zero_o`;
  - go to CALC.
- IDLE, `start_i`=1, divisor = 0:
  - quotient = all ones, remainder = dividend, `div_by_zero_o`=1;
  - go directly to DONE.
- CALC iteration, one per cycle:
  - trial = {remainder, quotient MSB} − {1'b0, divisor}, computed at width+1 bits with `sub_i`=1.
  - Borrow (adder `cout_o`=1): the remainder becomes {remainder[width-2:0], quotient MSB} (restore) and quotient shifts left inserting 0.
  - No borrow: the remainder becomes trial[width-1:0] and quotient shifts left inserting 1.
- Counter: increments each CALC cycle; after the `width`-th iteration the FSM goes to DONE.
- DONE: `done_o`=1 for that cycle, then unconditionally return to IDLE.
- `start_i` outside IDLE is ignored; there is no queueing. Operands are not re-sampled mid-operation.
- Invariant on every non-zero-divisor result: quotient × divisor + remainder = dividend, and remainder < divisor.
- Reset value of all outputs: 0. State resets to IDLE and the counter to 0.
- Asserting reset mid-operation aborts the operation immediately. There is no `done_o` for the aborted operation.

## Timing
- Start accepted at edge N:
  - `busy_o` is high from N.
  - Normal operation: CALC occupies edges N+1 … N+width, and DONE is entered at edge N+width. `done_o` is high in the cycle after edge N+width (width+1 cycles after acceptance). IDLE is re-entered at N+width+1.
  - Divide-by-zero: DONE is entered at N, so `done_o` is high in the cycle after N. IDLE is re-entered at N+1.
- `start_i` high in the cycle DONE returns to IDLE (i.e. sampled at that return edge) is accepted on the next edge. Back-to-back throughput is one division per width+2 cycles.
- `quotient_o`/`remainder_o` change only during CALC and at acceptance. They are stable and valid from the `done_o` cycle onward.

## Structure
- Shared package `calc_pkg` holds:
  - `div_state_t`, an enum of IDLE/CALC/DONE;
  - any operation codes the calculator control FSM uses to select this block.
- Counter width `$clog2(width+1)` is a local parameter, not a package item.
- One sub-module instance: `add_sub_nbits #(.width(width+1))` with `sub_i` tied to 1. Its `cout_o` is the borrow flag.

## Test plan
- width=8, 200 ÷ 7 → quotient 28, remainder 4, `div_by_zero_o`=0, `done_o` exactly 9 cycles after start.
- 255 ÷ 1 → quotient 255, remainder 0. Then 5 ÷ 9 → quotient 0, remainder 5. Run back-to-back with start held high continuously; each `done_o` is 10 cycles apart.
- 77 ÷ 0 → quotient 255, remainder 77, `div_by_zero_o`=1, `done_o` 1 cycle after start. The next 10 ÷ 3 gives 3 r 1 with `div_by_zero_o` cleared.
- Start 100 ÷ 3, pulse `start_i` again with 9 ÷ 9 at cycle 4 → the second request is ignored; the result is 33 r 1.
- Start 200 ÷ 7, drop `rst_ni` at cycle 4 → all outputs are 0 asynchronously, no `done_o` appears, and a subsequent 8 ÷ 2 gives 4 r 0.
- Random sweep of 10k operand pairs checked against the quotient/remainder invariant.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: divider FSM states and the operation codes
// the calculator control FSM uses to steer operands to the ALU or the divider.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_DIV
    } calc_op_t;

endpackage

// File: rtl/add_sub_nbits.sv
// Combinational adder/subtractor. In subtract mode cout_o is the borrow
// (high when a_i < b_i), so callers can use it directly as a "went negative" flag.
module add_sub_nbits #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             sub_i,
    output logic [width-1:0] sum_o,
    output logic             cout_o
);

    logic [width:0] full;

    // Two's-complement subtract; the raw carry is inverted to report a borrow.
    assign full   = {1'b0, a_i} + {1'b0, b_i ^ {width{sub_i}}} + {{width{1'b0}}, sub_i};
    assign sum_o  = full[width-1:0];
    assign cout_o = full[width] ^ sub_i;

endmodule

// File: rtl/div_seq_nbits.sv
// Sequential unsigned restoring divider: one shift-and-subtract step per cycle,
// launched by a start/done handshake from the calculator control FSM.
module div_seq_nbits
    import calc_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] quotient_o,
    output logic [width-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int cnt_w = $clog2(width + 1);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(width - 1);

    div_state_t       state_q, state_d;
    logic [cnt_w-1:0] count_q;
    logic [width-1:0] quot_q, rem_q, divisor_q;
    logic             dbz_q;

    logic [width:0]   trial_a, trial_b, trial;
    logic             borrow;
    logic             unused_trial_msb;

    assign trial_a = {rem_q, quot_q[width-1]};
    assign trial_b = {1'b0, divisor_q};

    add_sub_nbits #(.width(width + 1)) u_trial_sub (
        .a_i    (trial_a),
        .b_i    (trial_b),
        .sub_i  (1'b1),
        .sum_o  (trial),
        .cout_o (borrow)
    );

    // Remainder stays below the divisor, so a successful trial always fits in width bits.
    assign unused_trial_msb = trial[width];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (divisor_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_q == last_count) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        divisor_q <= divisor_i;
                        count_q   <= '0;
                        if (divisor_i == '0) begin
                            quot_q <= '1;
                            rem_q  <= dividend_i;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= dividend_i;
                            rem_q  <= '0;
                            dbz_q  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    count_q <= count_q + cnt_w'(1);
                    if (borrow) begin
                        rem_q  <= {rem_q[width-2:0], quot_q[width-1]};
                        quot_q <= {quot_q[width-2:0], 1'b0};
                    end else begin
                        rem_q  <= trial[width-1:0];
                        quot_q <= {quot_q[width-2:0], 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule
